// File: rtl/riscv_dcache_pkg.sv
// Shared types and helpers for the dcache memory-side line transfer engine.
// Holds the transfer FSM state encoding and the default bus/line geometry.
package riscv_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } dcache_mem_state_e;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_LINE_W = 128;

  function automatic logic [DEF_ADDR_W-1:0] line_base(input logic [DEF_ADDR_W-1:0] addr,
                                                      input int unsigned off_bits);
    logic [DEF_ADDR_W-1:0] mask;
    mask = ~((DEF_ADDR_W'(1) << off_bits) - DEF_ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/riscv_dcache_mem_if.sv
// Splits dcache line write-backs/fills into ascending single-word bus beats; all outputs registered.
// Latency BEATS+1 cycles from accept to mem_ready with bus_ack high; each beat holds until bus_ack.
module riscv_dcache_mem_if
  import riscv_dcache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rden,
  input  logic              mem_wren,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              mem_ready,
  output logic [LINE_W-1:0] fill_line,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int BEATS      = LINE_W / DATA_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS   = $clog2(LINE_W / 8);
  localparam int BEAT_BYTES = DATA_W / 8;

  if (((LINE_W % DATA_W) != 0) || (BEATS < 2)) begin : g_bad_cfg
    $error("riscv_dcache_mem_if: LINE_W must be a multiple of DATA_W with at least 2 beats");
  end

  dcache_mem_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt, w_req_base;
  logic [LINE_W-1:0] r_wb, w_wb_nxt;
  logic              w_ack, w_last, w_busy_nxt;

  logic              r_mem_ready, r_bus_req, r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [LINE_W-1:0] r_fill;

  assign w_req_base = ADDR_W'(line_base(DEF_ADDR_W'(mem_addr), OFF_BITS));
  assign w_ack      = bus_ack & r_bus_req;
  assign w_last     = (r_cnt == CNT_W'(BEATS - 1));
  assign w_busy_nxt = (w_state_nxt == WRITE) || (w_state_nxt == READ);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_base_nxt  = r_base;
    w_wb_nxt    = r_wb;
    case (r_state)
      IDLE: begin
        if (mem_wren) begin
          w_state_nxt = WRITE;
          w_base_nxt  = w_req_base;
          w_wb_nxt    = wb_line;
          w_cnt_nxt   = '0;
        end else if (mem_rden) begin
          w_state_nxt = READ;
          w_base_nxt  = w_req_base;
          w_cnt_nxt   = '0;
        end
      end
      WRITE, READ: begin
        if (w_ack) begin
          if (w_last) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_base  <= w_base_nxt;
      r_wb    <= w_wb_nxt;
    end
  end

  // Bus outputs are computed from next-state so a beat is presented the cycle after accept/ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ready <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_fill      <= '0;
    end else begin
      r_mem_ready <= (w_state_nxt == DONE);
      r_bus_req   <= w_busy_nxt;
      r_bus_we    <= (w_state_nxt == WRITE);
      if (w_busy_nxt) begin
        r_bus_addr  <= w_base_nxt + ADDR_W'(w_cnt_nxt) * ADDR_W'(BEAT_BYTES);
        r_bus_wdata <= w_wb_nxt[w_cnt_nxt*DATA_W +: DATA_W];
      end
      if ((r_state == READ) && w_ack) begin
        r_fill[r_cnt*DATA_W +: DATA_W] <= bus_rdata;
      end
    end
  end

  assign mem_ready = r_mem_ready;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign fill_line = r_fill;

endmodule

// File: tb/tb_riscv_dcache_mem_if.sv
// Bench for riscv_dcache_mem_if: directed scenarios plus random lines against a line-level model.
module tb_riscv_dcache_mem_if;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 128;
  localparam int NB = LW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rden = 1'b0;
  logic          mem_wren = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [LW-1:0] wb_line = '0;
  logic          mem_ready;
  logic [LW-1:0] fill_line;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of one line transfer, filled by the bus responder.
  logic [AW-1:0] obs_addr[$];
  logic          obs_we[$];
  logic [DW-1:0] obs_wd[$];
  int            obs_ready, obs_lat, obs_first, obs_stalls, obs_extra_req;
  bit            obs_stable;
  // Reference refill line: the words handed out on read acks, by beat position.
  logic [LW-1:0] model_fill = '0;

  riscv_dcache_mem_if dut (
    .clk(clk), .rst(rst),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .wb_line(wb_line),
    .mem_ready(mem_ready), .fill_line(fill_line),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] base_of(input logic [AW-1:0] a);
    return a & ~64'(LW / 8 - 1);
  endfunction

  // Drives one request and acts as the memory bus until mem_ready plus 'tail' cycles.
  task automatic xfer(input bit wr, input bit rd, input logic [AW-1:0] addr, input logic [LW-1:0] wl,
                      input int smin, input int smax, input bit spur, input bit drop,
                      input bit keep_rd, input int tail);
    int cyc = 0;
    int done = 0;
    int stall = 0;
    bit pend = 0;
    logic [AW-1:0] ha;
    logic [DW-1:0] hw;
    logic [DW-1:0] rv;
    ha = '0; hw = '0;
    obs_addr.delete(); obs_we.delete(); obs_wd.delete();
    obs_ready = 0; obs_lat = -1; obs_first = -1; obs_stalls = 0; obs_extra_req = 0; obs_stable = 1;
    mem_wren = wr; mem_rden = rd; mem_addr = addr; wb_line = wl;
    while (cyc < 300 && !(obs_lat >= 0 && cyc >= obs_lat + tail)) begin
      @(posedge clk); #1; cyc++;
      bus_ack = 1'b0;
      if (mem_ready) begin
        obs_ready++;
        if (obs_lat < 0) obs_lat = cyc;
        mem_wren = 1'b0;
        mem_rden = keep_rd;
      end
      if (bus_req) begin
        if (done >= NB) obs_extra_req++;
        else begin
          if (!pend) begin
            pend = 1; ha = bus_addr; hw = bus_wdata;
            obs_addr.push_back(bus_addr); obs_we.push_back(bus_we); obs_wd.push_back(bus_wdata);
            stall = int'($urandom_range(smax, smin));
            if (obs_first < 0) obs_first = cyc;
          end else if (bus_addr !== ha || bus_wdata !== hw) obs_stable = 0;
          if (stall == 0) begin
            bus_ack = 1'b1; pend = 0;
            if (!bus_we) begin
              rv = {$urandom, $urandom};
              bus_rdata = rv;
              model_fill[done*DW +: DW] = rv;
            end
            done++;
            if (drop) begin mem_wren = 1'b0; mem_rden = 1'b0; end
          end else begin
            stall--; obs_stalls++;
          end
        end
      end else if (spur) begin
        bus_ack = 1'b1;
        bus_rdata = {$urandom, $urandom};
      end
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({mem_ready, bus_req, bus_we} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {mem_ready, bus_req, bus_we}); end
    n_cmp++; if (bus_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", bus_wdata); end
    n_cmp++; if (fill_line !== '0) begin n_bad++; $display("FAIL reset_fill: got %h want 0", fill_line); end
    rst = 1'b0;
    model_fill = '0;
  endtask

  task automatic test_read_basic();
    xfer(1'b0, 1'b1, 64'h1008, '0, 0, 0, 1'b0, 1'b0, 1'b0, 2);
    n_cmp++; if (obs_addr.size() !== NB) begin n_bad++; $display("FAIL rd_beats: got %0d want %0d", obs_addr.size(), NB); end
    n_cmp++; if (obs_addr[0] !== 64'h1000) begin n_bad++; $display("FAIL rd_addr0: got %h want 1000", obs_addr[0]); end
    n_cmp++; if (obs_addr[1] !== 64'h1008) begin n_bad++; $display("FAIL rd_addr1: got %h want 1008", obs_addr[1]); end
    n_cmp++; if ({obs_we[0], obs_we[1]} !== 2'b00) begin n_bad++; $display("FAIL rd_we: got %b%b want 00", obs_we[0], obs_we[1]); end
    n_cmp++; if (obs_first !== 1) begin n_bad++; $display("FAIL rd_first_req: got %0d want 1", obs_first); end
    n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", obs_lat); end
    n_cmp++; if (obs_ready !== 1) begin n_bad++; $display("FAIL rd_ready_pulses: got %0d want 1", obs_ready); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL rd_fill: got %h want %h", fill_line, model_fill); end
  endtask

  task automatic test_write_stall();
    logic [LW-1:0] fill_before;
    fill_before = model_fill;
    xfer(1'b1, 1'b0, 64'h0000_0000_0004_2030, {64'hDEAD, 64'hBEEF}, 3, 3, 1'b0, 1'b0, 1'b0, 2);
    n_cmp++; if (obs_wd[0] !== 64'hBEEF) begin n_bad++; $display("FAIL wr_wdata0: got %h want beef", obs_wd[0]); end
    n_cmp++; if (obs_wd[1] !== 64'hDEAD) begin n_bad++; $display("FAIL wr_wdata1: got %h want dead", obs_wd[1]); end
    n_cmp++; if ({obs_we[0], obs_we[1]} !== 2'b11) begin n_bad++; $display("FAIL wr_we: got %b%b want 11", obs_we[0], obs_we[1]); end
    n_cmp++; if (obs_addr[1] !== 64'h42038) begin n_bad++; $display("FAIL wr_addr1: got %h want 42038", obs_addr[1]); end
    n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL wr_stall_stable: got %b want 1", obs_stable); end
    n_cmp++; if (obs_lat !== NB + 1 + 6) begin n_bad++; $display("FAIL wr_latency: got %0d want %0d", obs_lat, NB + 7); end
    n_cmp++; if (obs_ready !== 1) begin n_bad++; $display("FAIL wr_ready_pulses: got %0d want 1", obs_ready); end
    n_cmp++; if (fill_line !== fill_before) begin n_bad++; $display("FAIL wr_fill_kept: got %h want %h", fill_line, fill_before); end
  endtask

  task automatic test_wb_then_alloc();
    logic [AW-1:0] a;
    logic [LW-1:0] wl;
    a = {$urandom, $urandom};
    wl = {$urandom, $urandom, $urandom, $urandom};
    xfer(1'b1, 1'b1, a, wl, 0, 0, 1'b0, 1'b0, 1'b1, 1);
    n_cmp++; if ({obs_we[0], obs_we[1]} !== 2'b11) begin n_bad++; $display("FAIL wa_write_first: got %b%b want 11", obs_we[0], obs_we[1]); end
    n_cmp++; if ({obs_wd[1], obs_wd[0]} !== wl) begin n_bad++; $display("FAIL wa_wdata: got %h%h want %h", obs_wd[1], obs_wd[0], wl); end
    n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL wa_wr_latency: got %0d want 3", obs_lat); end
    xfer(1'b0, 1'b1, a, '0, 0, 0, 1'b0, 1'b0, 1'b0, 2);
    n_cmp++; if (obs_first !== 1) begin n_bad++; $display("FAIL wa_rd_accept: got %0d want 1", obs_first); end
    n_cmp++; if (obs_addr[0] !== base_of(a) || obs_we[0] !== 1'b0) begin n_bad++; $display("FAIL wa_rd_base: got %h we %b want %h we 0", obs_addr[0], obs_we[0], base_of(a)); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL wa_rd_fill: got %h want %h", fill_line, model_fill); end
  endtask

  task automatic test_reset_mid_read();
    int pulses = 0;
    mem_rden = 1'b1; mem_addr = 64'h2040;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    bus_ack = 1'b0;
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 64'h2048) begin n_bad++; $display("FAIL rm_beat1: got req %b addr %h want 1 2048", bus_req, bus_addr); end
    rst = 1'b1; mem_rden = 1'b0;
    #1;
    n_cmp++; if ({mem_ready, bus_req, bus_we, bus_addr, bus_wdata, fill_line} !== '0) begin n_bad++; $display("FAIL rm_outputs_zero: got req %b addr %h fill %h want 0", bus_req, bus_addr, fill_line); end
    repeat (3) begin @(posedge clk); #1; if (mem_ready) pulses++; end
    rst = 1'b0;
    model_fill = '0;
    repeat (2) begin @(posedge clk); #1; if (mem_ready || bus_req) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rm_no_ready: got %0d want 0", pulses); end
    xfer(1'b0, 1'b1, 64'h3018, '0, 0, 1, 1'b0, 1'b0, 1'b0, 2);
    n_cmp++; if (obs_addr[0] !== 64'h3010) begin n_bad++; $display("FAIL rm_restart_beat0: got %h want 3010", obs_addr[0]); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL rm_restart_fill: got %h want %h", fill_line, model_fill); end
  endtask

  task automatic test_spurious_ack();
    int bad = 0;
    repeat (4) begin
      bus_ack = 1'b1; bus_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      if (bus_req || mem_ready) bad++;
    end
    bus_ack = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL sp_idle_state: got %0d active cycles want 0", bad); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL sp_idle_fill: got %h want %h", fill_line, model_fill); end
    xfer(1'b0, 1'b1, {$urandom, $urandom}, '0, 0, 2, 1'b1, 1'b0, 1'b0, 3);
    n_cmp++; if (obs_ready !== 1 || obs_extra_req !== 0) begin n_bad++; $display("FAIL sp_done_state: got %0d pulses %0d extra want 1 0", obs_ready, obs_extra_req); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL sp_done_fill: got %h want %h", fill_line, model_fill); end
  endtask

  task automatic test_drop_request();
    xfer(1'b0, 1'b1, {$urandom, $urandom}, '0, 0, 2, 1'b0, 1'b1, 1'b0, 5);
    n_cmp++; if (obs_addr.size() !== NB) begin n_bad++; $display("FAIL dr_beats: got %0d want %0d", obs_addr.size(), NB); end
    n_cmp++; if (obs_ready !== 1) begin n_bad++; $display("FAIL dr_ready_pulses: got %0d want 1", obs_ready); end
    n_cmp++; if (obs_extra_req !== 0) begin n_bad++; $display("FAIL dr_stays_idle: got %0d want 0", obs_extra_req); end
    n_cmp++; if (fill_line !== model_fill) begin n_bad++; $display("FAIL dr_fill: got %h want %h", fill_line, model_fill); end
  endtask

  task automatic test_random_lines();
    for (int n = 0; n < 40; n++) begin
      bit wr;
      logic [AW-1:0] a;
      logic [LW-1:0] wl;
      logic [LW-1:0] fill_before;
      wr = $urandom_range(1, 0) == 1;
      a = {$urandom, $urandom};
      wl = {$urandom, $urandom, $urandom, $urandom};
      fill_before = model_fill;
      xfer(wr, !wr, a, wl, 0, 3, $urandom_range(1, 0) == 1, 1'b0, 1'b0, 2);
      n_cmp++; if (obs_addr.size() !== NB) begin n_bad++; $display("FAIL rnd_beats[%0d]: got %0d want %0d", n, obs_addr.size(), NB); end
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (obs_addr[i] !== base_of(a) + 64'(i * (DW / 8)) || obs_we[i] !== wr ||
            (wr && obs_wd[i] !== wl[i*DW +: DW])) begin
          n_bad++;
          $display("FAIL rnd_beat[%0d.%0d]: got addr %h we %b wd %h want addr %h we %b wd %h", n, i,
                   obs_addr[i], obs_we[i], obs_wd[i], base_of(a) + 64'(i * (DW / 8)), wr, wl[i*DW +: DW]);
        end
      end
      n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL rnd_stable[%0d]: got %b want 1", n, obs_stable); end
      n_cmp++; if (obs_lat !== NB + 1 + obs_stalls || obs_ready !== 1) begin n_bad++; $display("FAIL rnd_ready[%0d]: got lat %0d pulses %0d want lat %0d pulses 1", n, obs_lat, obs_ready, NB + 1 + obs_stalls); end
      n_cmp++; if (fill_line !== (wr ? fill_before : model_fill)) begin n_bad++; $display("FAIL rnd_fill[%0d]: got %h want %h", n, fill_line, wr ? fill_before : model_fill); end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_wb_then_alloc();
    test_reset_mid_read();
    test_spurious_ack();
    test_drop_request();
    test_random_lines();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
